// File: rtl/instruction_encoder.sv
// Packs ARM-style instruction field bundles into 32-bit words and writes them
// sequentially into an instruction-memory window. Optional macro: ENC_ERRCHK_EN.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [3:0]            cond,
    input  logic [4:0]            opcode,
    input  logic [3:0]            rn,
    input  logic [3:0]            rd,
    input  logic [3:0]            rm,
    input  logic                  immediateOperand,
    input  logic                  CPSRwrite,
    input  logic [1:0]            shiftType,
    input  logic [4:0]            rm_shift,
    input  logic [7:0]            immediateVal,
    input  logic [3:0]            rotateVal,
    input  logic [7:0]            rm_shiftSDT,
    input  logic [11:0]           immediateOffset,
    input  logic                  prePostAddOffset,
    input  logic                  upDownOffset,
    input  logic                  byteOrWord,
    input  logic                  writeBack,
    input  logic                  loadStore,
    input  logic                  linkBit,
    input  logic [23:0]           branchImmediate,
    output logic                  memWrEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memData,
    output logic [ADDR_WIDTH:0]   wordCount,
    output logic                  full,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state, state_nx;
    logic [31:0]         word_q, word_d;
    logic [ADDR_WIDTH:0] count_q;
    logic                accept, take;

    always_comb begin
        word_d = {cond, 28'h0000000};
        if (!opcode[4]) begin
            word_d = {cond, 2'b00, immediateOperand, opcode[3:0], CPSRwrite, rn, rd,
                      immediateOperand ? {rotateVal, immediateVal}
                                       : {rm_shift, shiftType, 1'b0, rm}};
        end else if (opcode == 5'b10000) begin
            word_d = {cond, 2'b01, immediateOperand, prePostAddOffset, upDownOffset,
                      byteOrWord, writeBack, loadStore, rn, rd,
                      immediateOperand ? {rm_shiftSDT, rm} : immediateOffset};
        end else if (opcode == 5'b10001) begin
            word_d = {cond, 3'b101, linkBit, branchImmediate};
        end
    end

    assign accept = (state == IDLE) && inValid && !clear;

`ifdef ENC_ERRCHK_EN
    logic illegal;
    logic error_q;
    assign illegal = opcode[4] && (opcode[3:1] != 3'b000);
    // Rejected opcodes are consumed but never leave IDLE, so the pointer holds.
    assign take    = accept && !illegal;
    assign error   = error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (accept && illegal) begin
            error_q <= 1'b1;
        end
    end
`else
    assign take  = accept;
    assign error = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = WRITE;
            WRITE:   state_nx = (count_q == DEPTH - ONE) ? FULL : IDLE;
            FULL:    state_nx = FULL;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                count_q <= '0;
            end else if (state == WRITE) begin
                count_q <= count_q + ONE;
            end
            if (take) word_q <= word_d;
        end
    end

    assign inReady   = (state == IDLE) && !clear && !reset;
    assign memWrEn   = (state == WRITE) && !clear && !reset;
    assign memAddr   = count_q[ADDR_WIDTH-1:0];
    assign memData   = memWrEn ? word_q : '0;
    assign wordCount = count_q;
    assign full      = (state == FULL);

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: fixed vectors, randomized bundles
// against an arithmetic reference encoder, clear/reset/full corner cases.
module tb_instruction_encoder;

    typedef struct packed {
        logic [3:0]  cond;
        logic [4:0]  opcode;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic        i;
        logic        s;
        logic [1:0]  sh;
        logic [4:0]  rsh;
        logic [7:0]  imm;
        logic [3:0]  rot;
        logic [7:0]  rsdt;
        logic [11:0] ioff;
        logic        p;
        logic        u;
        logic        b;
        logic        wb;
        logic        l;
        logic        link;
        logic [23:0] bimm;
    } bundle_t;

`ifdef ENC_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, clear, inValid;
    logic [3:0]  cond, rn, rd, rm, rotateVal;
    logic [4:0]  opcode, rm_shift;
    logic        immediateOperand, CPSRwrite;
    logic [1:0]  shiftType;
    logic [7:0]  immediateVal, rm_shiftSDT;
    logic [11:0] immediateOffset;
    logic        prePostAddOffset, upDownOffset, byteOrWord, writeBack, loadStore, linkBit;
    logic [23:0] branchImmediate;

    logic        inReady, memWrEn, full, error;
    logic [5:0]  memAddr;
    logic [31:0] memData;
    logic [6:0]  wordCount;

    logic        inReady2, memWrEn2, full2, error2;
    logic [1:0]  memAddr2;
    logic [31:0] memData2;
    logic [2:0]  wordCount2;

    int passed = 0;
    int total  = 0;
    int exp_count = 0;
    int wr2_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (memWrEn2 === 1'b1) wr2_count <= wr2_count + 1;

    instruction_encoder dut (
        .clk(clk), .reset(reset), .clear(clear), .inValid(inValid), .inReady(inReady),
        .cond(cond), .opcode(opcode), .rn(rn), .rd(rd), .rm(rm),
        .immediateOperand(immediateOperand), .CPSRwrite(CPSRwrite), .shiftType(shiftType),
        .rm_shift(rm_shift), .immediateVal(immediateVal), .rotateVal(rotateVal),
        .rm_shiftSDT(rm_shiftSDT), .immediateOffset(immediateOffset),
        .prePostAddOffset(prePostAddOffset), .upDownOffset(upDownOffset),
        .byteOrWord(byteOrWord), .writeBack(writeBack), .loadStore(loadStore),
        .linkBit(linkBit), .branchImmediate(branchImmediate),
        .memWrEn(memWrEn), .memAddr(memAddr), .memData(memData),
        .wordCount(wordCount), .full(full), .error(error)
    );

    instruction_encoder #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .inValid(inValid), .inReady(inReady2),
        .cond(cond), .opcode(opcode), .rn(rn), .rd(rd), .rm(rm),
        .immediateOperand(immediateOperand), .CPSRwrite(CPSRwrite), .shiftType(shiftType),
        .rm_shift(rm_shift), .immediateVal(immediateVal), .rotateVal(rotateVal),
        .rm_shiftSDT(rm_shiftSDT), .immediateOffset(immediateOffset),
        .prePostAddOffset(prePostAddOffset), .upDownOffset(upDownOffset),
        .byteOrWord(byteOrWord), .writeBack(writeBack), .loadStore(loadStore),
        .linkBit(linkBit), .branchImmediate(branchImmediate),
        .memWrEn(memWrEn2), .memAddr(memAddr2), .memData(memData2),
        .wordCount(wordCount2), .full(full2), .error(error2)
    );

    // Reference encoder: fields weighted by their bit position.
    function automatic logic [31:0] ref_word(input bundle_t x);
        longint w;
        longint op;
        op = longint'(x.opcode);
        w  = longint'(x.cond) * (2**28);
        if (op < 16) begin
            w += longint'(x.i) * (2**25) + op * (2**21) + longint'(x.s) * (2**20)
               + longint'(x.rn) * (2**16) + longint'(x.rd) * (2**12);
            if (x.i) w += longint'(x.rot) * 256 + longint'(x.imm);
            else     w += longint'(x.rsh) * 128 + longint'(x.sh) * 32 + longint'(x.rm);
        end else if (op == 16) begin
            w += (2**26) + longint'(x.i) * (2**25) + longint'(x.p) * (2**24)
               + longint'(x.u) * (2**23) + longint'(x.b) * (2**22) + longint'(x.wb) * (2**21)
               + longint'(x.l) * (2**20) + longint'(x.rn) * (2**16) + longint'(x.rd) * (2**12);
            if (x.i) w += longint'(x.rsdt) * 16 + longint'(x.rm);
            else     w += longint'(x.ioff);
        end else if (op == 17) begin
            w += 5 * (2**25) + longint'(x.link) * (2**24) + longint'(x.bimm);
        end
        return w[31:0];
    endfunction

    function automatic bundle_t rand_bundle(input int unsigned max_op);
        logic [127:0] r;
        bundle_t x;
        r = {$urandom, $urandom, $urandom, $urandom};
        x = bundle_t'(r[$bits(bundle_t)-1:0]);
        x.opcode = 5'($urandom_range(0, max_op));
        return x;
    endfunction

    task automatic drive(input bundle_t x);
        cond = x.cond; opcode = x.opcode; rn = x.rn; rd = x.rd; rm = x.rm;
        immediateOperand = x.i; CPSRwrite = x.s; shiftType = x.sh; rm_shift = x.rsh;
        immediateVal = x.imm; rotateVal = x.rot; rm_shiftSDT = x.rsdt;
        immediateOffset = x.ioff; prePostAddOffset = x.p; upDownOffset = x.u;
        byteOrWord = x.b; writeBack = x.wb; loadStore = x.l; linkBit = x.link;
        branchImmediate = x.bimm;
    endtask

    // Presents a bundle until accepted (bounded); returns one cycle after acceptance.
    task automatic present(input bundle_t x, input bit use2, output bit ok);
        drive(x);
        inValid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if ((use2 ? inReady2 : inReady) === 1'b1) begin
                @(posedge clk); #1;
                inValid = 1'b0;
                #1;
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; inValid = 1'b0;
        drive('0);
        @(posedge clk); #1;
        total++; if (inReady !== 1'b0) $display("FAIL reset_inready: got %b expected 0", inReady); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (inReady !== 1'b1) $display("FAIL post_reset_inready: got %b expected 1", inReady); else passed++;
        total++; if (memWrEn !== 1'b0 || memData !== 32'h0) $display("FAIL reset_mem: got we=%b data=%h expected 0/0", memWrEn, memData); else passed++;
        total++; if (wordCount !== 7'd0 || full !== 1'b0 || error !== 1'b0) $display("FAIL reset_state: got wc=%0d full=%b err=%b expected 0/0/0", wordCount, full, error); else passed++;
        exp_count = 0;
    endtask

    task automatic test_vectors();
        bundle_t v[4];
        logic [31:0] want[4];
        bit ok;
        v[0] = '0; v[0].opcode = 5'b00100; v[0].cond = 4'hE; v[0].i = 1'b1; v[0].rn = 4'hD; v[0].rd = 4'hB; v[0].imm = 8'h04;
        v[1] = '0; v[1].opcode = 5'b10000; v[1].cond = 4'hE; v[1].p = 1'b1; v[1].u = 1'b1; v[1].l = 1'b1; v[1].rn = 4'hF; v[1].ioff = 12'h014;
        v[2] = '0; v[2].opcode = 5'b10001; v[2].cond = 4'hE; v[2].link = 1'b1; v[2].bimm = 24'hFFFFFE;
        v[3] = '0; v[3].opcode = 5'b01101; v[3].cond = 4'hE; v[3].i = 1'b1; v[3].rd = 4'h3;
        want[0] = 32'hE28DB004; want[1] = 32'hE59F0014; want[2] = 32'hEBFFFFFE; want[3] = 32'hE3A03000;
        for (int k = 0; k < 4; k++) begin
            present(v[k], 1'b0, ok);
            total++; if (!ok) $display("FAIL vec_accept[%0d]: got timeout expected accept", k); else passed++;
            total++;
            if (memWrEn !== 1'b1 || memAddr !== 6'(exp_count) || memData !== want[k])
                $display("FAIL vec_write[%0d]: got we=%b addr=%0d data=%h expected 1/%0d/%h", k, memWrEn, memAddr, memData, exp_count, want[k]);
            else passed++;
            exp_count++;
        end
        @(posedge clk); #1;
        total++; if (wordCount !== 7'(exp_count)) $display("FAIL vec_count: got %0d expected %0d", wordCount, exp_count); else passed++;
    endtask

    task automatic test_illegal();
        bundle_t x;
        bit ok;
        x = '0; x.opcode = 5'b10010; x.cond = 4'hE;
        present(x, 1'b0, ok);
        total++; if (!ok) $display("FAIL ill_accept: got timeout expected accept"); else passed++;
`ifdef ENC_ERRCHK_EN
        total++; if (memWrEn !== 1'b0) $display("FAIL ill_nowrite: got we=%b expected 0", memWrEn); else passed++;
        @(posedge clk); #1;
        total++; if (error !== 1'b1 || wordCount !== 7'(exp_count)) $display("FAIL ill_err: got err=%b wc=%0d expected 1/%0d", error, wordCount, exp_count); else passed++;
`else
        total++;
        if (memWrEn !== 1'b1 || memAddr !== 6'(exp_count) || memData !== 32'hE0000000)
            $display("FAIL ill_write: got we=%b addr=%0d data=%h expected 1/%0d/e0000000", memWrEn, memAddr, memData, exp_count);
        else passed++;
        exp_count++;
        @(posedge clk); #1;
        total++; if (error !== 1'b0 || wordCount !== 7'(exp_count)) $display("FAIL ill_err: got err=%b wc=%0d expected 0/%0d", error, wordCount, exp_count); else passed++;
`endif
    endtask

    task automatic test_random();
        bundle_t x;
        bit ok, ill, wr;
        for (int k = 0; k < 40; k++) begin
            x = rand_bundle(31);
            ill = (x.opcode >= 5'd18);
            wr = !(ill && ERRCHK);
            present(x, 1'b0, ok);
            total++;
            if (!ok || memWrEn !== wr || (wr && (memAddr !== 6'(exp_count) || memData !== ref_word(x))))
                $display("FAIL rnd_write[%0d]: got ok=%b we=%b addr=%0d data=%h expected 1/%b/%0d/%h", k, ok, memWrEn, memAddr, memData, wr, exp_count, ref_word(x));
            else passed++;
            if (wr) exp_count++;
            @(posedge clk); #1;
            total++;
            if (memWrEn !== 1'b0 || memData !== 32'h0 || wordCount !== 7'(exp_count) || error !== (ERRCHK && (ill || error)))
                $display("FAIL rnd_idle[%0d]: got we=%b data=%h wc=%0d err=%b expected 0/0/%0d", k, memWrEn, memData, wordCount, error, exp_count);
            else passed++;
        end
    endtask

    task automatic test_clear();
        bundle_t x;
        bit ok, err0;
        err0 = error;
        drive(rand_bundle(17));
        clear = 1'b1; inValid = 1'b1;
        #1;
        total++; if (inReady !== 1'b0) $display("FAIL clr_inready: got %b expected 0", inReady); else passed++;
        @(posedge clk); #1;
        clear = 1'b0; inValid = 1'b0;
        #1;
        total++; if (memWrEn !== 1'b0 || wordCount !== 7'd0 || error !== err0) $display("FAIL clr_noaccept: got we=%b wc=%0d err=%b expected 0/0/%b", memWrEn, wordCount, error, err0); else passed++;
        x = rand_bundle(17);
        present(x, 1'b0, ok);
        clear = 1'b1;
        #1;
        total++; if (!ok || memWrEn !== 1'b0 || memData !== 32'h0) $display("FAIL clr_cancel: got ok=%b we=%b data=%h expected 1/0/0", ok, memWrEn, memData); else passed++;
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        total++; if (wordCount !== 7'd0 || inReady !== 1'b1) $display("FAIL clr_after: got wc=%0d rdy=%b expected 0/1", wordCount, inReady); else passed++;
        exp_count = 0;
    endtask

    task automatic test_reset_write();
        bit ok;
        present(rand_bundle(17), 1'b0, ok);
        total++; if (!ok || memWrEn !== 1'b1) $display("FAIL rw_pending: got ok=%b we=%b expected 1/1", ok, memWrEn); else passed++;
        reset = 1'b1;
        #1;
        total++; if (memWrEn !== 1'b0 || inReady !== 1'b0) $display("FAIL rw_abort: got we=%b rdy=%b expected 0/0", memWrEn, inReady); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (wordCount !== 7'd0 || error !== 1'b0 || memWrEn !== 1'b0) $display("FAIL rw_after: got wc=%0d err=%b we=%b expected 0/0/0", wordCount, error, memWrEn); else passed++;
        exp_count = 0;
    endtask

    task automatic test_full();
        bundle_t x;
        bit ok;
        int base;
        base = wr2_count;
        for (int k = 0; k < 4; k++) begin
            x = rand_bundle(17);
            present(x, 1'b1, ok);
            total++;
            if (!ok || memWrEn2 !== 1'b1 || memAddr2 !== 2'(k) || memData2 !== ref_word(x))
                $display("FAIL full_write[%0d]: got ok=%b we=%b addr=%0d data=%h expected 1/1/%0d/%h", k, ok, memWrEn2, memAddr2, memData2, k, ref_word(x));
            else passed++;
        end
        @(posedge clk); #1;
        total++; if (full2 !== 1'b1 || inReady2 !== 1'b0 || wordCount2 !== 3'd4) $display("FAIL full_state: got full=%b rdy=%b wc=%0d expected 1/0/4", full2, inReady2, wordCount2); else passed++;
        present(rand_bundle(17), 1'b1, ok);
        total++; if (ok) $display("FAIL full_refuse: got accept expected refused"); else passed++;
        total++; if (wr2_count - base !== 4 || wordCount2 !== 3'd4) $display("FAIL full_writes: got %0d writes wc=%0d expected 4/4", wr2_count - base, wordCount2); else passed++;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        total++; if (full2 !== 1'b0 || wordCount2 !== 3'd0) $display("FAIL full_clear: got full=%b wc=%0d expected 0/0", full2, wordCount2); else passed++;
        x = rand_bundle(17);
        present(x, 1'b1, ok);
        total++; if (!ok || memWrEn2 !== 1'b1 || memAddr2 !== 2'd0 || memData2 !== ref_word(x)) $display("FAIL full_restart: got ok=%b we=%b addr=%0d data=%h expected 1/1/0/%h", ok, memWrEn2, memAddr2, memData2, ref_word(x)); else passed++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_illegal();
        test_random();
        test_clear();
        test_reset_write();
        test_full();
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6; it sets the log2 depth of the instruction-memory window (64 words).
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  restart the fill at address 0.
- inValid  in  1  field bundle valid.
- inReady  out  1  encoder can accept a bundle.
- cond  in  4  condition field.
- opcode  in  5  00000-01111 data processing (ALU op = opcode[3:0]); 10000 load/store; 10001 branch; 10010-11111 illegal.
- rn, rd, rm  in  4 each  register numbers.
- immediateOperand  in  1  I bit.
- CPSRwrite  in  1  S bit.
- shiftType  in  2  register shift type.
- rm_shift  in  5  data-processing shift amount.
- immediateVal  in  8  data-processing immediate.
- rotateVal  in  4  data-processing immediate rotate.
- rm_shiftSDT  in  8  load/store register-offset shift field.
- immediateOffset  in  12  load/store immediate offset.
- prePostAddOffset, upDownOffset, byteOrWord, writeBack, loadStore  in  1 each  P, U, B, W, L bits.
- linkBit  in  1  branch-with-link bit.
- branchImmediate  in  24  branch offset.
- memWrEn  out  1  instruction-memory write strobe.
- memAddr  out  ADDR_WIDTH  word address.
- memData  out  32  encoded instruction.
- wordCount  out  ADDR_WIDTH+1  number of words written.
- full  out  1  window full.
- error  out  1  sticky illegal-opcode flag.

Function
REQ-003 SHALL implement an FSM with three states:
- IDLE: inReady=1.
- WRITE: inReady=0, memWrEn=1.
- FULL: inReady=0, full=1.
REQ-004 SHALL accept a bundle on any rising edge where inValid=1, inReady=1 and clear=0. All fields are registered, and the state moves to WRITE.
REQ-005 In WRITE, SHALL drive memWrEn=1 for exactly one cycle with memAddr equal to the current pointer and memData equal to the encoded word. This is a latency of 1 cycle from acceptance.
REQ-006 At the end of WRITE, SHALL increment the pointer and wordCount. The next state is FULL if wordCount reaches 2^ADDR_WIDTH, otherwise IDLE. Throughput is therefore one word per 2 cycles.
REQ-007 Data-processing encoding SHALL be:
- [31:28]=cond, [27:26]=00, [25]=I, [24:21]=opcode[3:0], [20]=S, [19:16]=rn, [15:12]=rd.
- [11:0]={rotateVal,immediateVal} when I=1.
- [11:0]={rm_shift,shiftType,1'b0,rm} when I=0.
REQ-008 Load/store encoding SHALL be:
- [31:28]=cond, [27:26]=01, [25]=I, [24:20]={P,U,B,W,L}, [19:16]=rn, [15:12]=rd.
- [11:0]=immediateOffset when I=0.
- [11:0]={rm_shiftSDT[7:0],rm} when I=1.
REQ-009 Branch encoding SHALL be: [31:28]=cond, [27:25]=101, [24]=linkBit, [23:0]=branchImmediate.
REQ-010 When memWrEn=0, memData SHALL hold 0.
REQ-011 In FULL, the pointer SHALL NOT wrap, no writes SHALL occur, and bundles SHALL be refused until clear or reset.
REQ-012 clear=1 SHALL take priority over everything else in every state:
- next cycle: pointer=0, wordCount=0, state IDLE;
- error is preserved;
- any write pending in WRITE is cancelled, so memWrEn=0 in the cycle clear is high;
- inReady SHALL be 0 while clear=1.

Reset
REQ-013 reset=1 at a rising edge SHALL force state IDLE, pointer=0, wordCount=0, error=0, memWrEn=0 and memData=0, aborting any in-flight write.
REQ-014 inReady SHALL be 0 during the cycle reset is asserted.

Configuration
REQ-015 Macro ENC_ERRCHK_EN, when defined:
- an accepted illegal opcode (10010-11111) produces no write;
- error is set and stays set until reset;
- the pointer is unchanged and the FSM returns to IDLE the next cycle.
REQ-016 Without ENC_ERRCHK_EN:
- an illegal opcode is written as {cond,28'h0000000} and the pointer advances normally;
- error is tied to 0.

Verification
REQ-017 ADD: opcode=00100, cond=E, I=1, S=0, rn=D, rd=B, rotateVal=0, immediateVal=04 -> next cycle memWrEn=1, memAddr=0, memData=E28DB004.
REQ-018 LDR: opcode=10000, cond=E, I=0, P=1, U=1, B=0, W=0, L=1, rn=F, rd=0, immediateOffset=014 -> memData=E59F0014 at addr 1.
REQ-019 BL: opcode=10001, cond=E, linkBit=1, branchImmediate=FFFFFE -> memData=EBFFFFFE. Then MOV: opcode=01101, I=1, rd=3, imm=00 -> memData=E3A03000 at next addr.
REQ-020 With ADDR_WIDTH=2, stream 5 bundles -> exactly 4 writes at addrs 0-3, then full=1, inReady=0, wordCount=4. Then pulse clear -> full=0, next write at addr 0.
REQ-021 Assert clear in the same cycle as inValid=1 -> bundle not accepted. Assert reset during WRITE -> no memWrEn that cycle, wordCount=0.
REQ-022 Illegal opcode 10010 with cond=E, run in both builds:
- with ENC_ERRCHK_EN: no write, error=1, pointer held;
- without ENC_ERRCHK_EN: memData=E0000000, error=0.
